// File: rtl/csr_pkg.sv
// csr_pkg: shared constants, coefficient type and mod-2^W negation for coef_shift_reg
package csr_pkg;
  localparam int CSR_N = 4;
  localparam int CSR_W = 2;
  typedef logic [CSR_W-1:0] coef_t;
  function automatic coef_t neg_mod(coef_t x);
    return ~x + coef_t'(1);
  endfunction
endpackage

// File: rtl/coef_neg.sv
// coef_neg: mod-4 negator on the negacyclic wrap path
module coef_neg
  import csr_pkg::*;
(
  input  coef_t a,
  output coef_t y
);
  assign y = neg_mod(a);
endmodule

// File: rtl/coef_shift_reg.sv
// coef_shift_reg: loads a 4-term poly from bit planes, then multiplies by x every clock
// CSR_NEGACYCLIC_EN defined: x^4 = -1 (wrap negated); undefined: plain cyclic rotation
module coef_shift_reg
  import csr_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [CSR_N-1:0] data0,
  input  logic [CSR_N-1:0] data1,
  output coef_t            coef0,
  output coef_t            coef1,
  output coef_t            coef2,
  output coef_t            coef3
);
  coef_t c [CSR_N];
  coef_t wrap;
  logic  loaded;
`ifdef CSR_NEGACYCLIC_EN
  coef_neg u_neg (.a(c[CSR_N-1]), .y(wrap));
`else
  assign wrap = c[CSR_N-1];
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < CSR_N; i++) c[i] <= '0;
      loaded <= 1'b0;
    end else if (!loaded) begin
      for (int i = 0; i < CSR_N; i++) c[i] <= {data1[i], data0[i]};
      loaded <= 1'b1;
    end else begin
      c[0] <= wrap;
      for (int i = 1; i < CSR_N; i++) c[i] <= c[i-1];
    end
  assign coef0 = c[0];
  assign coef1 = c[1];
  assign coef2 = c[2];
  assign coef3 = c[3];
endmodule

// File: tb/tb_coef_shift_reg.sv
// tb_coef_shift_reg: random + directed checks of coef_shift_reg against a polynomial model
module tb_coef_shift_reg;
`ifdef CSR_NEGACYCLIC_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] data0 = 4'b1010, data1 = 4'b1100;
  logic [1:0] coef0, coef1, coef2, coef3;
  int total = 0, bad = 0;
  int p [4];
  int k = 0;
  bit loaded = 0;

  coef_shift_reg dut (.clk(clk), .reset(reset), .data0(data0), .data1(data1),
                      .coef0(coef0), .coef1(coef1), .coef2(coef2), .coef3(coef3));

  always #5 clk = ~clk;

  // model: the held value is x^k * p in Z_4[x]/(x^4 -/+ 1)
  always @(posedge clk or posedge reset)
    if (reset) begin
      loaded = 0; k = 0;
    end else if (!loaded) begin
      for (int i = 0; i < 4; i++) p[i] = 2*int'(data1[i]) + int'(data0[i]);
      loaded = 1; k = 0;
    end else k = k + 1;

  function automatic int expect_coef(int i);
    int v;
    v = 0;
    if (loaded)
      for (int j = 0; j < 4; j++)
        if ((j + k) % 4 == i) v = (NEG && (((j + k) / 4) % 2 == 1)) ? (4 - p[j]) % 4 : p[j];
    return v;
  endfunction

  function automatic int dut_coef(int i);
    return i == 0 ? int'(coef0) : i == 1 ? int'(coef1) : i == 2 ? int'(coef2) : int'(coef3);
  endfunction

  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_coef(i) != expect_coef(i)) begin
        bad++;
        $display("FAIL model coef%0d k=%0d got=%0d want=%0d", i, k, dut_coef(i), expect_coef(i));
      end
    end

  task automatic check_lit(string name, int e0, int e1, int e2, int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (dut_coef(i) != e[i]) begin
        bad++;
        $display("FAIL %s coef%0d got=%0d want=%0d", name, i, dut_coef(i), e[i]);
      end
    end
  endtask

  int neg_tab [8][4] = '{'{1,0,1,2}, '{2,1,0,1}, '{3,2,1,0}, '{0,3,2,1},
                         '{3,0,3,2}, '{2,3,0,3}, '{1,2,3,0}, '{0,1,2,3}};
  int cyc_tab [4][4] = '{'{3,0,1,2}, '{2,3,0,1}, '{1,2,3,0}, '{0,1,2,3}};

  initial begin
    repeat (3) begin
      @(negedge clk); check_lit("reset_hold", 0, 0, 0, 0);
      #2 check_lit("reset_hold_mid", 0, 0, 0, 0);
    end
    @(negedge clk) reset = 1'b0;
    @(negedge clk) check_lit("load", 0, 1, 2, 3);
    for (int s = 0; s < 8; s++) begin
      data0 = 4'($urandom); data1 = 4'($urandom);
      @(negedge clk);
      if (NEG) check_lit("shift", neg_tab[s][0], neg_tab[s][1], neg_tab[s][2], neg_tab[s][3]);
      else check_lit("shift", cyc_tab[s%4][0], cyc_tab[s%4][1], cyc_tab[s%4][2], cyc_tab[s%4][3]);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_lit("async_reset", 0, 0, 0, 0);
    data1 = 4'b0000; data0 = 4'b1111;
    @(negedge clk) reset = 1'b0;
    @(negedge clk) check_lit("reload", 1, 1, 1, 1);
    for (int r = 0; r < 40; r++) begin
      data0 = 4'($urandom); data1 = 4'($urandom);
      repeat ($urandom_range(1, 12)) begin
        @(negedge clk);
        data0 = 4'($urandom); data1 = 4'($urandom);
      end
      @(posedge clk);
      #($urandom_range(1, 4)) reset = 1'b1;
      #1 check_lit("rand_async_reset", 0, 0, 0, 0);
      @(negedge clk) reset = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
